arb_switch_ff: RTL and testbench

// 2x2 self-routing switch element for the multistage interconnect network.

---
 rtl/arb_switch_ff_if.sv | 31 +++
 rtl/arb_switch_ff.sv | 102 ++++++++++
 tb/tb_arb_switch_ff.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/arb_switch_ff_if.sv
// Flit ports of the 2x2 self-routing switch element; slave is the switch side.
interface arb_switch_ff_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] left_in;
  logic             left_in_valid;
  logic             left_in_ready;
  logic [WIDTH-1:0] right_in;
  logic             right_in_valid;
  logic             right_in_ready;
  logic [WIDTH-1:0] left_out;
  logic             left_out_valid;
  logic             left_out_ready;
  logic [WIDTH-1:0] right_out;
  logic             right_out_valid;
  logic             right_out_ready;

  modport slave (
    input  left_in, left_in_valid, right_in, right_in_valid,
    output left_in_ready, right_in_ready,
    output left_out, left_out_valid, right_out, right_out_valid,
    input  left_out_ready, right_out_ready
  );

  modport master (
    output left_in, left_in_valid, right_in, right_in_valid,
    input  left_in_ready, right_in_ready,
    input  left_out, left_out_valid, right_out, right_out_valid,
    output left_out_ready, right_out_ready
  );
endinterface

// File: rtl/arb_switch_ff.sv
// 2x2 self-routing switch: per-input 2-deep FIFOs, round-robin per output, registered outputs.
// One-cycle FIFO-to-output latency; in_ready falls when a FIFO holds 2 flits, outputs hold while stalled.
module arb_switch_ff #(
  parameter int WIDTH     = 64,
  parameter int ROUTE_BIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_switch_ff_if.slave bus
);

  // index 0 = left, 1 = right (inputs and outputs alike)
  logic [WIDTH-1:0] in_dat [2];
  logic [1:0]       in_vld;
  logic [1:0]       in_rdy;
  logic [1:0]       out_rdy;

  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       cnt [2];

  logic [WIDTH-1:0] head [2];
  logic [1:0]       not_empty;
  logic [1:0]       dest;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       cand [2];
  logic [1:0]       free;
  logic [1:0]       gnt;
  logic [1:0]       win;
  logic [1:0]       rr;

  logic [WIDTH-1:0] out_dat [2];
  logic [1:0]       out_vld;

  assign in_dat[0] = bus.left_in;
  assign in_dat[1] = bus.right_in;
  assign in_vld    = {bus.right_in_valid, bus.left_in_valid};
  assign out_rdy   = {bus.right_out_ready, bus.left_out_ready};

  assign bus.left_in_ready   = in_rdy[0];
  assign bus.right_in_ready  = in_rdy[1];
  assign bus.left_out        = out_dat[0];
  assign bus.left_out_valid  = out_vld[0];
  assign bus.right_out       = out_dat[1];
  assign bus.right_out_valid = out_vld[1];

  always_comb begin
    pop = '0;
    for (int i = 0; i < 2; i++) begin
      // ready comes from the registered count only, so a full FIFO never takes a flit
      in_rdy[i]    = (cnt[i] != 2'd2);
      push[i]      = in_vld[i] && in_rdy[i];
      head[i]      = mem[i][rd_ptr[i]];
      not_empty[i] = (cnt[i] != 2'd0);
      dest[i]      = head[i][ROUTE_BIT];
    end
    for (int x = 0; x < 2; x++) begin
      cand[x] = not_empty & ((x == 0) ? ~dest : dest);
      free[x] = !out_vld[x] || out_rdy[x];
      win[x]  = (cand[x] == 2'b11) ? rr[x] : cand[x][1];
      gnt[x]  = (|cand[x]) && free[x];
    end
    for (int x = 0; x < 2; x++) begin
      if (gnt[x]) pop[win[x]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i][0]  <= '0;
        mem[i][1]  <= '0;
        cnt[i]     <= '0;
        out_dat[i] <= '0;
      end
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rr      <= '0;
      out_vld <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= in_dat[i];
          wr_ptr[i]         <= ~wr_ptr[i];
        end
        if (pop[i]) rd_ptr[i] <= ~rd_ptr[i];
        cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
      for (int x = 0; x < 2; x++) begin
        if (free[x]) begin
          out_vld[x] <= gnt[x];
          if (gnt[x]) out_dat[x] <= head[win[x]];
          // pointer moves only when both inputs wanted this output
          if (gnt[x] && (cand[x] == 2'b11)) rr[x] <= ~rr[x];
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_switch_ff.sv
// Directed scoreboard bench for arb_switch_ff: reset, straight, conflict, backpressure, reset pulse.
module tb_arb_switch_ff;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_switch_ff_if #(.WIDTH(W)) bus ();

  arb_switch_ff #(.WIDTH(W), .ROUTE_BIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  logic [W-1:0] lq[$];
  logic [W-1:0] rq[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every completed output handshake must match the queue head
  always @(negedge clk) begin
    if (rst_n && bus.left_out_valid && bus.left_out_ready) begin
      if (lq.size() == 0) begin
        total++; bad++;
        $error("FAIL left_unexpected: got %0h want none", bus.left_out);
      end else chk("left_order", bus.left_out, lq.pop_front());
    end
    if (rst_n && bus.right_out_valid && bus.right_out_ready) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $error("FAIL right_unexpected: got %0h want none", bus.right_out);
      end else chk("right_order", bus.right_out, rq.pop_front());
    end
  end

  // present one flit on a side and hold it until accepted; returns 1 ns after the accepting edge
  task automatic drive(input bit side, input logic [W-1:0] d);
    logic r;
    int n = 0;
    if (!side) begin bus.left_in = d; bus.left_in_valid = 1'b1; end
    else begin bus.right_in = d; bus.right_in_valid = 1'b1; end
    forever begin
      r = side ? bus.right_in_ready : bus.left_in_ready;
      @(posedge clk); #1;
      if (r) begin acc_cnt++; break; end
      n++;
      if (n > 100) begin
        total++; bad++;
        $error("FAIL drive_timeout: side %0d flit %0h got not-accepted want accepted", side, d);
        break;
      end
    end
    if (!side) bus.left_in_valid = 1'b0;
    else bus.right_in_valid = 1'b0;
  endtask

  task automatic stream(input bit side, input logic [W-1:0] base, input int n, input int step);
    for (int k = 0; k < n; k++) drive(side, base + W'(k * step));
  endtask

  task automatic drain();
    int n = 0;
    while ((lq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", W'(lq.size()), '0);
    chk("drain_right", W'(rq.size()), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.left_in = '0; bus.right_in = '0;
    bus.left_out_ready = 1'b1; bus.right_out_ready = 1'b1;

    // reset held with valids high
    rst_n = 1'b0;
    bus.left_in = 64'h10; bus.left_in_valid = 1'b1;
    bus.right_in = 64'h21; bus.right_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left_valid", bus.left_out_valid, 0);
    chk("rst_right_valid", bus.right_out_valid, 0);
    chk("rst_left_out", bus.left_out, 0);
    chk("rst_right_out", bus.right_out, 0);
    rst_n = 1'b1;
    bus.left_in_valid = 1'b0; bus.right_in_valid = 1'b0;
    chk("rel_left_ready", bus.left_in_ready, 1);
    chk("rel_right_ready", bus.right_in_ready, 1);
    @(posedge clk); #1;
    chk("idle_left_valid", bus.left_out_valid, 0);

    // straight route with one-edge latency
    lq.push_back(64'h10); rq.push_back(64'h21);
    fork
      drive(1'b0, 64'h10);
      drive(1'b1, 64'h21);
    join
    chk("lat0_left_valid", bus.left_out_valid, 0);
    @(posedge clk); #1;
    chk("lat1_left_valid", bus.left_out_valid, 1);
    chk("lat1_left_out", bus.left_out, 64'h10);
    chk("lat1_right_valid", bus.right_out_valid, 1);
    chk("lat1_right_out", bus.right_out, 64'h21);
    drain();

    // conflict: both inputs to left, strict alternation starting with left
    for (int k = 0; k < 6; k++) begin
      lq.push_back(W'(2 + 2 * k));
      lq.push_back(W'(6 + 2 * k));
    end
    fork
      stream(1'b0, 64'h2, 6, 2);
      stream(1'b1, 64'h6, 6, 2);
    join
    drain();

    // backpressure: one flit parks in the output register, two more fill the FIFO
    bus.left_out_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 8; k++) lq.push_back(W'(64'h40 + 2 * k));
    fork
      stream(1'b0, 64'h40, 8, 2);
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", W'(acc_cnt), W'(3));
        chk("bp_in_ready", bus.left_in_ready, 0);
        chk("bp_hold_valid", bus.left_out_valid, 1);
        chk("bp_hold_out", bus.left_out, 64'h40);
        bus.left_out_ready = 1'b1;
      end
    join
    drain();

    // fill both paths, then pulse reset asynchronously
    bus.left_out_ready = 1'b0; bus.right_out_ready = 1'b0;
    fork
      stream(1'b0, 64'h100, 3, 2);
      stream(1'b1, 64'h201, 3, 2);
    join
    chk("full_left_ready", bus.left_in_ready, 0);
    chk("full_right_ready", bus.right_in_ready, 0);
    chk("full_right_valid", bus.right_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("pulse_left_valid", bus.left_out_valid, 0);
    chk("pulse_right_valid", bus.right_out_valid, 0);
    chk("pulse_left_out", bus.left_out, 0);
    chk("pulse_right_out", bus.right_out, 0);
    chk("pulse_left_ready", bus.left_in_ready, 1);
    chk("pulse_right_ready", bus.right_in_ready, 1);
    bus.left_out_ready = 1'b1; bus.right_out_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // after reset the left input wins the first contested grant
    lq.push_back(64'h80); lq.push_back(64'h90);
    fork
      drive(1'b0, 64'h80);
      drive(1'b1, 64'h90);
    join
    @(posedge clk); #1;
    chk("post_left_valid", bus.left_out_valid, 1);
    chk("post_left_first", bus.left_out, 64'h80);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
